// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART frame encodings, TX state type and frame length helper
package uart_pkg;

   localparam int PAR_NONE = 0;
   localparam int PAR_ODD  = 1;
   localparam int PAR_EVEN = 2;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      PAR   = 3'd3,
      STOP  = 3'd4
   } tx_state_t;

   function automatic int frame_bits(input int data_bits, input int parity, input int stop_bits);
      return 1 + data_bits + ((parity != PAR_NONE) ? 1 : 0) + stop_bits;
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - BIT_TIME-modulo bit timer with synchronous restart and one-cycle tick
module uart_baud_tick #(
   parameter int BIT_TIME = 10
) (
   input  logic clk,
   input  logic rst_n,
   input  logic restart,
   output logic tick
);

   localparam int CW = $clog2(BIT_TIME);
   localparam logic [CW-1:0] LAST = CW'(BIT_TIME - 1);

   logic [CW-1:0] count;

   assign tick = !restart && (count == LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (restart || tick) begin
         count <= '0;
      end else begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/uart_tx_framed.sv
// rtl/uart_tx_framed.sv - framed UART transmitter with one-entry holding register and status outputs
module uart_tx_framed
   import uart_pkg::*;
#(
   parameter int CLOCK_FREQ = 125_000_000,
   parameter int BAUD_RATE  = 115_200,
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [DATA_BITS-1:0] data_in,
   input  logic                 data_in_valid,
   output logic                 data_in_ready,
   output logic                 serial_out,
   output logic                 busy,
   output logic                 frame_done
);

   localparam int BIT_TIME   = CLOCK_FREQ / BAUD_RATE;
   localparam int FRAME_BITS = frame_bits(DATA_BITS, PARITY, STOP_BITS);
   localparam int CW         = $clog2(FRAME_BITS);
   localparam logic [CW-1:0] LAST_DATA = CW'(DATA_BITS);
   localparam logic [CW-1:0] LAST_BIT  = CW'(FRAME_BITS - 1);

   if (BIT_TIME < 2 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY < PAR_NONE || PARITY > PAR_EVEN ||
       STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_params
      $fatal(1, "uart_tx_framed: illegal frame or baud parameters");
   end

   tx_state_t            state;
   tx_state_t            state_next;
   logic [DATA_BITS-1:0] hold_data;
   logic                 hold_valid;
   logic [DATA_BITS-1:0] shift;
   logic                 par_q;
   logic [CW-1:0]        bit_cnt;
   logic                 bit_tick;
   logic                 baud_restart;
   logic                 last_stop;
   logic                 load;
   logic                 accept;
   logic                 line_next;

   // bit_cnt indexes the frame bit: 0 = start, 1..DATA_BITS = data, then parity and stops
   assign baud_restart  = (state == IDLE);
   assign last_stop     = (state == STOP) && bit_tick && (bit_cnt == LAST_BIT);
   assign load          = hold_valid && ((state == IDLE) || last_stop);
   assign data_in_ready = ~hold_valid;
   assign accept        = data_in_valid && data_in_ready;

   uart_baud_tick #(
      .BIT_TIME (BIT_TIME)
   ) u_baud (
      .clk     (clk),
      .rst_n   (rst_n),
      .restart (baud_restart),
      .tick    (bit_tick)
   );

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (hold_valid) state_next = START;
         START:   if (bit_tick) state_next = DATA;
         DATA:    if (bit_tick && bit_cnt == LAST_DATA) state_next = (PARITY != PAR_NONE) ? PAR : STOP;
         PAR:     if (bit_tick) state_next = STOP;
         STOP:    if (last_stop) state_next = hold_valid ? START : IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      line_next = 1'b1;
      case (state)
         START:   line_next = 1'b0;
         DATA:    line_next = shift[0];
         PAR:     line_next = par_q;
         default: line_next = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_valid <= 1'b0;
         hold_data  <= '0;
      end else if (accept) begin
         hold_valid <= 1'b1;
         hold_data  <= data_in;
      end else if (load) begin
         hold_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shift   <= '0;
         par_q   <= 1'b0;
         bit_cnt <= '0;
      end else if (load) begin
         shift   <= hold_data;
         par_q   <= (^hold_data) ^ (PARITY == PAR_ODD);
         bit_cnt <= '0;
      end else if (bit_tick && state != IDLE) begin
         bit_cnt <= bit_cnt + 1'b1;
         if (state == DATA) shift <= shift >> 1;
      end
   end

   // Outputs are registered one cycle behind the state so they line up with the pin
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         serial_out <= 1'b1;
         frame_done <= 1'b0;
         busy       <= 1'b0;
      end else begin
         serial_out <= line_next;
         frame_done <= last_stop;
         busy       <= (state != IDLE) || hold_valid;
      end
   end

endmodule

// File: tb/tb_uart_tx_framed.sv
// tb/tb_uart_tx_framed.sv - self-checking bench for uart_tx_framed (8N1, 8E1, 7O2 instances)
module tb_uart_tx_framed;

   localparam int CF   = 1000;
   localparam int BR   = 100;
   localparam int BT   = CF / BR;
   localparam int NREC = 4096;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   logic [7:0] din0, din1;
   logic [6:0] din2;
   logic v0, v1, v2, rd0, rd1, rd2, so0, so1, so2, bz0, bz1, bz2, fd0, fd1, fd2;

   uart_tx_framed #(.CLOCK_FREQ(CF), .BAUD_RATE(BR), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
      .clk(clk), .rst_n(rst_n), .data_in(din0), .data_in_valid(v0), .data_in_ready(rd0),
      .serial_out(so0), .busy(bz0), .frame_done(fd0));
   uart_tx_framed #(.CLOCK_FREQ(CF), .BAUD_RATE(BR), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_8e1 (
      .clk(clk), .rst_n(rst_n), .data_in(din1), .data_in_valid(v1), .data_in_ready(rd1),
      .serial_out(so1), .busy(bz1), .frame_done(fd1));
   uart_tx_framed #(.CLOCK_FREQ(CF), .BAUD_RATE(BR), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) u_7o2 (
      .clk(clk), .rst_n(rst_n), .data_in(din2), .data_in_valid(v2), .data_in_ready(rd2),
      .serial_out(so2), .busy(bz2), .frame_done(fd2));

   logic rec_line  [3][NREC];
   logic rec_fd    [3][NREC];
   logic rec_busy  [3][NREC];
   logic rec_ready [3][NREC];
   logic exp_line  [NREC];

   int checks = 0;
   int errors = 0;

   always @(negedge clk) begin
      if (cyc < NREC) begin
         rec_line[0][cyc] = so0;  rec_fd[0][cyc] = fd0;  rec_busy[0][cyc] = bz0;  rec_ready[0][cyc] = rd0;
         rec_line[1][cyc] = so1;  rec_fd[1][cyc] = fd1;  rec_busy[1][cyc] = bz1;  rec_ready[1][cyc] = rd1;
         rec_line[2][cyc] = so2;  rec_fd[2][cyc] = fd2;  rec_busy[2][cyc] = bz2;  rec_ready[2][cyc] = rd2;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic logic ready_of(input int d);
      return (d == 0) ? rd0 : (d == 1) ? rd1 : rd2;
   endfunction

   task automatic drive(input int d, input logic [8:0] w, input logic v);
      case (d)
         0: begin din0 = w[7:0]; v0 = v; end
         1: begin din1 = w[7:0]; v1 = v; end
         default: begin din2 = w[6:0]; v2 = v; end
      endcase
   endtask

   // Offer a word and return the edge number at which it was accepted
   task automatic send(input int d, input logic [8:0] w, input bit keep, output int acc);
      logic r;
      acc = -1;
      drive(d, w, 1'b1);
      for (int n = 0; n < 400; n++) begin
         r = ready_of(d);
         @(negedge clk);
         if (r) begin
            acc = cyc;
            break;
         end
      end
      if (!keep) drive(d, w, 1'b0);
      if (acc < 0) chk("accept_timeout", 0, 1);
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   task automatic fill_idle(input int from, input int to);
      for (int c = from; c <= to && c < NREC; c++) exp_line[c] = 1'b1;
   endtask

   // Reference frame: start, data LSB first, optional parity, stops; each bit BT cycles
   task automatic put_frame(input int start, input logic [8:0] w, input int db, input int par,
                            input int sb, output int last);
      logic bits[$];
      int   ones = 0;
      int   pos = start;
      bits.push_back(1'b0);
      for (int i = 0; i < db; i++) begin
         bits.push_back(w[i]);
         ones += int'(w[i]);
      end
      if (par == 1) bits.push_back((ones % 2) == 0);
      if (par == 2) bits.push_back((ones % 2) == 1);
      for (int i = 0; i < sb; i++) bits.push_back(1'b1);
      foreach (bits[i]) begin
         for (int k = 0; k < BT; k++) begin
            if (pos < NREC) exp_line[pos] = bits[i];
            pos++;
         end
      end
      last = pos - 1;
   endtask

   function automatic int line_errs(input int d, input int from, input int to);
      int n = 0;
      for (int c = from; c <= to && c < NREC; c++) if (rec_line[d][c] !== exp_line[c]) n++;
      return n;
   endfunction

   function automatic int fd_count(input int d, input int from, input int to);
      int n = 0;
      for (int c = from; c <= to && c < NREC; c++) if (rec_fd[d][c] === 1'b1) n++;
      return n;
   endfunction

   function automatic int fd_nth(input int d, input int from, input int to, input int nth);
      int k = 0;
      for (int c = from; c <= to && c < NREC; c++) begin
         if (rec_fd[d][c] === 1'b1) begin
            if (k == nth) return c;
            k++;
         end
      end
      return -1;
   endfunction

   initial begin
      int acc, acc2, last, last2, s2, r;
      int accs[4];
      int ends[4];
      logic [8:0] w, w2;
      logic [8:0] ws[4];

      drive(0, 9'h0, 1'b0);
      drive(1, 9'h0, 1'b0);
      drive(2, 9'h0, 1'b0);
      repeat (3) @(negedge clk);
      chk("rst_line", {29'd0, so0, so1, so2}, 32'd7);
      chk("rst_ready", {29'd0, rd0, rd1, rd2}, 32'd7);
      chk("rst_busy", {29'd0, bz0, bz1, bz2}, 32'd0);
      chk("rst_frame_done", {29'd0, fd0, fd1, fd2}, 32'd0);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      // 8N1, 0x55 from idle
      send(0, 9'h055, 0, acc);
      chk("t1_ready_after_accept", rd0, 0);
      wait_until(acc + 130);
      fill_idle(acc, acc + 129);
      put_frame(acc + 2, 9'h055, 8, 0, 1, last);
      chk("t1_line", line_errs(0, acc, acc + 129), 0);
      chk("t1_idle_before_start", rec_line[0][acc + 1], 1);
      chk("t1_start_at_t2", rec_line[0][acc + 2], 0);
      chk("t1_fd_count", fd_count(0, acc, acc + 129), 1);
      chk("t1_fd_cycle", fd_nth(0, acc, acc + 129, 0), last);
      chk("t1_busy_last", rec_busy[0][last], 1);
      chk("t1_busy_drop", rec_busy[0][last + 1], 0);

      // 8E1, 0x07: three ones so the even parity bit is 1
      send(1, 9'h007, 0, acc);
      wait_until(acc + 130);
      fill_idle(acc, acc + 129);
      put_frame(acc + 2, 9'h007, 8, 2, 1, last);
      chk("t2_line", line_errs(1, acc, acc + 129), 0);
      chk("t2_parity_bit", rec_line[1][acc + 2 + 95], 1);
      chk("t2_fd_cycle", fd_nth(1, acc, acc + 129, 0), last);
      chk("t2_busy_last", rec_busy[1][last], 1);
      chk("t2_busy_drop", rec_busy[1][last + 1], 0);

      // 7O2, 0x00: odd parity bit is 1, then two stop bits
      send(2, 9'h000, 0, acc);
      wait_until(acc + 130);
      fill_idle(acc, acc + 129);
      put_frame(acc + 2, 9'h000, 7, 1, 2, last);
      chk("t3_line", line_errs(2, acc, acc + 129), 0);
      chk("t3_parity_bit", rec_line[2][acc + 2 + 85], 1);
      chk("t3_fd_count", fd_count(2, acc, acc + 129), 1);
      chk("t3_fd_cycle", fd_nth(2, acc, acc + 129, 0), last);

      // 8N1 back-to-back, second word offered while the first is on the line
      w = 9'($urandom_range(0, 255));
      w2 = 9'($urandom_range(0, 255));
      send(0, w, 0, acc);
      repeat ($urandom_range(5, 60)) @(negedge clk);
      send(0, w2, 0, acc2);
      chk("t4_ready_drop", rd0, 0);
      put_frame(acc + 2, w, 8, 0, 1, last);
      s2 = (acc2 + 2 > last + 1) ? acc2 + 2 : last + 1;
      wait_until(s2 + 130);
      fill_idle(acc, s2 + 129);
      put_frame(acc + 2, w, 8, 0, 1, last);
      put_frame(s2, w2, 8, 0, 1, last2);
      chk("t4_line", line_errs(0, acc, s2 + 129), 0);
      chk("t4_fd_count", fd_count(0, acc, s2 + 129), 2);
      chk("t4_fd_first", fd_nth(0, acc, s2 + 129, 0), last);
      chk("t4_fd_second", fd_nth(0, acc, s2 + 129, 1), last2);

      // Reset during data bit 3 (forced to 0) with a second word held
      w = 9'($urandom_range(0, 255)) & 9'h0F7;
      send(0, w, 0, acc);
      send(0, 9'($urandom_range(0, 255)), 0, acc2);
      wait_until(acc + 2 + 44);
      chk("t5_line_low_before_reset", so0, 0);
      #2 rst_n = 1'b0;
      #1;
      chk("t5_line_async_high", so0, 1);
      chk("t5_ready_in_reset", rd0, 1);
      chk("t5_busy_in_reset", bz0, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      r = cyc;
      wait_until(r + 150);
      fill_idle(r, r + 149);
      chk("t5_line_idle_after", line_errs(0, r, r + 149), 0);
      chk("t5_no_frame_done", fd_count(0, acc, r + 149), 0);
      chk("t5_ready_after", rd0, 1);
      chk("t5_busy_after", bz0, 0);

      // 8N1, valid held high for four words
      for (int i = 0; i < 4; i++) begin
         ws[i] = 9'($urandom_range(0, 255));
         send(0, ws[i], (i < 3), accs[i]);
      end
      for (int i = 0; i < 4; i++) begin
         s2 = (i == 0) ? accs[0] + 2 : ((accs[i] + 2 > ends[i-1] + 1) ? accs[i] + 2 : ends[i-1] + 1);
         put_frame(s2, ws[i], 8, 0, 1, ends[i]);
      end
      wait_until(ends[3] + 20);
      fill_idle(accs[0], ends[3] + 19);
      for (int i = 0; i < 4; i++) begin
         s2 = (i == 0) ? accs[0] + 2 : ((accs[i] + 2 > ends[i-1] + 1) ? accs[i] + 2 : ends[i-1] + 1);
         put_frame(s2, ws[i], 8, 0, 1, ends[i]);
      end
      chk("t6_line", line_errs(0, accs[0], ends[3] + 19), 0);
      chk("t6_fd_count", fd_count(0, accs[0], ends[3] + 19), 4);
      for (int i = 0; i < 4; i++) chk("t6_fd_cycle", fd_nth(0, accs[0], ends[3] + 19, i), ends[i]);
      chk("t6_contiguous", ends[3] - (accs[0] + 2) + 1, 4 * 10 * BT);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
